// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if : requester/memory bundle for the two-port memory arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              iwReq0;
  logic              iwReq1;
  logic              iwWe0;
  logic              iwWe1;
  logic [AW-1:0]     iwAddr0;
  logic [AW-1:0]     iwAddr1;
  logic [DW-1:0]     iwWData0;
  logic [DW-1:0]     iwWData1;
  logic [DW/8-1:0]   iwWstrb0;
  logic [DW/8-1:0]   iwWstrb1;
  logic              owGnt0;
  logic              owGnt1;
  logic              owRValid0;
  logic              owRValid1;
  logic [DW-1:0]     owRData0;
  logic [DW-1:0]     owRData1;
  logic [AW-1:0]     owMemAddr;
  logic [DW-1:0]     owMemWData;
  logic [DW/8-1:0]   owMemWstrb;
  logic              owMemRen;
  logic [DW-1:0]     iwMemRData;

  // Arbiter side
  modport slave (
    input  iwReq0, iwReq1, iwWe0, iwWe1, iwAddr0, iwAddr1,
           iwWData0, iwWData1, iwWstrb0, iwWstrb1, iwMemRData,
    output owGnt0, owGnt1, owRValid0, owRValid1, owRData0, owRData1,
           owMemAddr, owMemWData, owMemWstrb, owMemRen
  );

  // Requesters plus memory device side
  modport master (
    output iwReq0, iwReq1, iwWe0, iwWe1, iwAddr0, iwAddr1,
           iwWData0, iwWData1, iwWstrb0, iwWstrb1, iwMemRData,
    input  owGnt0, owGnt1, owRValid0, owRValid1, owRData0, owRData1,
           owMemAddr, owMemWData, owMemWstrb, owMemRen
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : two-requester round-robin arbiter onto one synchronous memory
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  wire logic   iwClk,
  input  wire logic   iwRst,
  mem_arbiter_if.slave bus
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic            sel_q, sel_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;

  logic            w_grant;
  logic            w_pick;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_mem_ren;
  logic [SW-1:0]   w_mem_wstrb;
  logic            w_rvalid0;
  logic            w_rvalid1;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    sel_d       = sel_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    w_grant     = 1'b0;
    w_pick      = 1'b0;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_mem_ren   = 1'b0;
    w_mem_wstrb = '0;
    w_rvalid0   = 1'b0;
    w_rvalid1   = 1'b0;

    case (state_q)
      IDLE: begin
        // Priority pointer only breaks ties; a lone request always wins.
        if (bus.iwReq0 && bus.iwReq1) begin
          w_grant = 1'b1;
          w_pick  = prio_q;
        end else if (bus.iwReq0) begin
          w_grant = 1'b1;
          w_pick  = 1'b0;
        end else if (bus.iwReq1) begin
          w_grant = 1'b1;
          w_pick  = 1'b1;
        end

        if (w_grant) begin
          w_gnt0  = ~w_pick;
          w_gnt1  = w_pick;
          sel_d   = w_pick;
          prio_d  = ~w_pick;
          we_d    = w_pick ? bus.iwWe1    : bus.iwWe0;
          addr_d  = w_pick ? bus.iwAddr1  : bus.iwAddr0;
          wdata_d = w_pick ? bus.iwWData1 : bus.iwWData0;
          wstrb_d = w_pick ? bus.iwWstrb1 : bus.iwWstrb0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (we_q) begin
          w_mem_wstrb = wstrb_q;
          state_d     = IDLE;
        end else begin
          w_mem_ren = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        if (sel_q) begin
          w_rvalid1 = 1'b1;
          rdata1_d  = bus.iwMemRData;
        end else begin
          w_rvalid0 = 1'b1;
          rdata0_d  = bus.iwMemRData;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Every output is forced low while reset is held, aborting any in-flight access.
  assign bus.owGnt0     = w_gnt0 & ~iwRst;
  assign bus.owGnt1     = w_gnt1 & ~iwRst;
  assign bus.owRValid0  = w_rvalid0 & ~iwRst;
  assign bus.owRValid1  = w_rvalid1 & ~iwRst;
  assign bus.owRData0   = iwRst ? '0 : (w_rvalid0 ? bus.iwMemRData : rdata0_q);
  assign bus.owRData1   = iwRst ? '0 : (w_rvalid1 ? bus.iwMemRData : rdata1_q);
  assign bus.owMemAddr  = iwRst ? '0 : addr_q;
  assign bus.owMemWData = iwRst ? '0 : wdata_q;
  assign bus.owMemWstrb = iwRst ? '0 : w_mem_wstrb;
  assign bus.owMemRen   = w_mem_ren & ~iwRst;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed and randomized bench with a transaction-level model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .iwClk (clk),
    .iwRst (rst),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h5A000000 + 32'(i) * 32'h00010203;
  endfunction

  // Synchronous memory device: read data valid the cycle after the read enable
  logic [DW-1:0] mem [NW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
      bus.iwMemRData <= '0;
    end else begin
      if (bus.owMemRen) bus.iwMemRData <= mem[bus.owMemAddr[5:2]];
      for (int b = 0; b < SW; b++)
        if (bus.owMemWstrb[b])
          mem[bus.owMemAddr[5:2]][b*8 +: 8] <= bus.owMemWData[b*8 +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Transaction-level reference: one access in flight, grant cycle g,
  // memory access at g+1, read response at g+2, arbiter free again at
  // g+2 (write) or g+3 (read).
  int            free_cyc = 0;
  bit            prio     = 1'b0;
  bit            have_t   = 1'b0;
  int            t_g      = 0;
  bit            t_src, t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rval;
  logic [SW-1:0] t_wstrb;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [DW-1:0] last_rd [2];
  logic [DW-1:0] mmem [NW];
  bit            saw_g0 = 1'b0;
  bit            saw_g1 = 1'b0;
  int            mode   = 0;   // 0 directed, 1 random, 2 both-read stream

  task automatic model_reset();
    prio      = 1'b0;
    have_t    = 1'b0;
    cap_addr  = '0;
    cap_wdata = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < NW; i++) mmem[i] = init_word(i);
    free_cyc  = cyc + 1;
  endtask

  task automatic model_cycle();
    bit            e_g0, e_g1, acc, resp;
    logic          e_ren;
    logic [SW-1:0] e_ws;
    logic          e_rv0, e_rv1;
    logic [DW-1:0] e_rd0, e_rd1;
    logic [3:0]    idx;
    bit            n;

    e_g0 = 1'b0;
    e_g1 = 1'b0;
    acc  = have_t && (cyc == t_g + 1);
    resp = have_t && !t_we && (cyc == t_g + 2);
    if (!rst && cyc >= free_cyc) begin
      if (bus.iwReq0 && bus.iwReq1) begin
        if (prio) e_g1 = 1'b1; else e_g0 = 1'b1;
      end else if (bus.iwReq0) e_g0 = 1'b1;
      else if (bus.iwReq1)     e_g1 = 1'b1;
    end
    e_ren = !rst && acc && !t_we;
    e_ws  = (!rst && acc && t_we) ? t_wstrb : '0;
    e_rv0 = !rst && resp && !t_src;
    e_rv1 = !rst && resp && t_src;
    e_rd0 = rst ? '0 : (e_rv0 ? t_rval : last_rd[0]);
    e_rd1 = rst ? '0 : (e_rv1 ? t_rval : last_rd[1]);

    chk("gnt0",     bus.owGnt0,     e_g0);
    chk("gnt1",     bus.owGnt1,     e_g1);
    chk("gnt_excl", bus.owGnt0 & bus.owGnt1, 1'b0);
    chk("mem_ren",  bus.owMemRen,   e_ren);
    chk("mem_wstrb",bus.owMemWstrb, e_ws);
    chk("mem_addr", bus.owMemAddr,  rst ? '0 : cap_addr);
    chk("mem_wdata",bus.owMemWData, rst ? '0 : cap_wdata);
    chk("rvalid0",  bus.owRValid0,  e_rv0);
    chk("rvalid1",  bus.owRValid1,  e_rv1);
    chk("rv_excl",  bus.owRValid0 & bus.owRValid1, 1'b0);
    chk("rdata0",   bus.owRData0,   e_rd0);
    chk("rdata1",   bus.owRData1,   e_rd1);

    saw_g0 = bus.owGnt0;
    saw_g1 = bus.owGnt1;

    if (rst) begin
      model_reset();
    end else begin
      idx = t_addr[5:2];
      if (acc) begin
        if (t_we) begin
          for (int b = 0; b < SW; b++)
            if (t_wstrb[b]) mmem[idx][b*8 +: 8] = t_wdata[b*8 +: 8];
        end else begin
          t_rval = mmem[idx];
        end
      end
      if (resp) last_rd[t_src] = t_rval;
      if (e_g0 || e_g1) begin
        n        = e_g1;
        t_src    = n;
        t_we     = n ? bus.iwWe1    : bus.iwWe0;
        t_addr   = n ? bus.iwAddr1  : bus.iwAddr0;
        t_wdata  = n ? bus.iwWData1 : bus.iwWData0;
        t_wstrb  = n ? bus.iwWstrb1 : bus.iwWstrb0;
        have_t   = 1'b1;
        t_g      = cyc;
        free_cyc = cyc + (t_we ? 2 : 3);
        prio     = !n;
        cap_addr  = t_addr;
        cap_wdata = t_wdata;
      end
    end
    cyc++;
  endtask

  task automatic drive_req(input bit n, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
    if (!n) begin
      bus.iwWe0 = we; bus.iwAddr0 = addr; bus.iwWData0 = wdata; bus.iwWstrb0 = wstrb;
      bus.iwReq0 = 1'b1;
    end else begin
      bus.iwWe1 = we; bus.iwAddr1 = addr; bus.iwWData1 = wdata; bus.iwWstrb1 = wstrb;
      bus.iwReq1 = 1'b1;
    end
  endtask

  task automatic rand_req(input bit n);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, NW - 1)) << 2;
    drive_req(n, 1'($urandom_range(0, 1)), a, $urandom, SW'($urandom_range(0, 15)));
  endtask

  // One clock: check at the falling edge, then act as requesters after the rising edge
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (saw_g0) begin
      bus.iwReq0 = 1'b0;
      if (mode == 2) drive_req(1'b0, 1'b0, 32'h40, '0, '0);
    end
    if (saw_g1) begin
      bus.iwReq1 = 1'b0;
      if (mode == 2) drive_req(1'b1, 1'b0, 32'h44, '0, '0);
    end
    if (mode == 1) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!bus.iwReq0 && $urandom_range(0, 2) != 0) rand_req(1'b0);
      if (!bus.iwReq1 && $urandom_range(0, 2) != 0) rand_req(1'b1);
    end
  endtask

  task automatic wait_any(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(saw_g0 || saw_g1) && k < 12);
    chk(tag, saw_g0 || saw_g1, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.iwReq0 = 1'b0; bus.iwReq1 = 1'b0;
    bus.iwWe0 = 1'b0;  bus.iwWe1 = 1'b0;
    bus.iwAddr0 = '0;  bus.iwAddr1 = '0;
    bus.iwWData0 = '0; bus.iwWData1 = '0;
    bus.iwWstrb0 = '0; bus.iwWstrb1 = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single read from requester 0
    drive_req(1'b0, 1'b0, 32'h10, '0, '0);
    repeat (3) step();
    chk("r031_hold", bus.owRData0, 32'hDEADBEEF);
    step();

    // Full-word write from requester 1
    drive_req(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    repeat (2) step();
    chk("r033_memword", mem[8], 32'h12345678);
    step();

    // Four back-to-back reads from requester 0, then a tie goes to requester 1
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 1'b0, AW'(i * 4), '0, '0);
      wait_any("r034_gnt");
      chk("r034_is0", saw_g0, 1'b1);
    end
    drive_req(1'b0, 1'b0, 32'h0, '0, '0);
    drive_req(1'b1, 1'b0, 32'h4, '0, '0);
    wait_any("r034_tie");
    chk("r034_first1", saw_g1, 1'b1);
    wait_any("r034_next");
    chk("r034_then0", saw_g0, 1'b1);
    repeat (4) step();

    // Zero-strobe write leaves memory untouched
    drive_req(1'b0, 1'b1, 32'h20, 32'hFFFF0000, 4'h0);
    repeat (3) step();
    chk("zero_strb", mem[8], 32'h12345678);

    // Continuous competing reads must alternate
    do_reset();
    mode = 2;
    drive_req(1'b0, 1'b0, 32'h40, '0, '0);
    drive_req(1'b1, 1'b0, 32'h44, '0, '0);
    repeat (15) step();
    mode = 0;
    bus.iwReq0 = 1'b0;
    bus.iwReq1 = 1'b0;
    repeat (4) step();

    // Reset while a read is in its memory-access cycle
    drive_req(1'b1, 1'b0, 32'h10, '0, '0);
    wait_any("r035_gnt");
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("r035_ren", bus.owMemRen, 1'b0);
    drive_req(1'b0, 1'b0, 32'h8, '0, '0);
    drive_req(1'b1, 1'b0, 32'hC, '0, '0);
    wait_any("r035_tie");
    chk("r035_prio0", saw_g0, 1'b1);
    repeat (4) step();

    // Randomized traffic with occasional resets
    mode = 1;
    repeat (400) step();
    mode = 0;
    rst = 1'b0;
    bus.iwReq0 = 1'b0;
    bus.iwReq1 = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
